// File: rtl/timer_scheduler_if.sv
// Command channel of timer_scheduler: valid/ready request with channel, op and period.
interface timer_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [1:0]       cfg_op;
  logic [CNT_W-1:0] cfg_period;
  logic             cfg_err;

  modport master (output cfg_valid, cfg_ch, cfg_op, cfg_period, input cfg_ready, cfg_err);
  modport slave  (input cfg_valid, cfg_ch, cfg_op, cfg_period, output cfg_ready, cfg_err);
endinterface

// File: rtl/timer_scheduler.sv
// Multi-channel one-shot/periodic tick timer with a shared command port.
// Optional sticky interrupt status is built when TIMER_SCHEDULER_IRQ_EN is defined.
module timer_scheduler_ch #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_i,
  input  logic             start_i,
  input  logic             periodic_i,
  input  logic             stop_i,
  input  logic [CNT_W-1:0] period_i,
  output logic             busy_o,
  output logic             expire_o
);
  typedef enum logic [1:0] {IDLE, ONESHOT, PERIODIC} ch_state_e;

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic             expire_q, expire_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      reload_q <= '0;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      reload_q <= reload_d;
      expire_q <= expire_d;
    end
  end

  // Commands and ticks never share a cycle, so start/stop take priority harmlessly.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    reload_d = reload_q;
    expire_d = 1'b0;
    if (start_i) begin
      state_d  = periodic_i ? PERIODIC : ONESHOT;
      rem_d    = period_i;
      reload_d = period_i;
    end else if (stop_i) begin
      state_d = IDLE;
      rem_d   = '0;
    end else if (tick_i && state_q != IDLE) begin
      if (rem_q == CNT_W'(1)) begin
        expire_d = 1'b1;
        if (state_q == ONESHOT) begin
          state_d = IDLE;
          rem_d   = '0;
        end else begin
          rem_d = reload_q;
        end
      end else begin
        rem_d = rem_q - CNT_W'(1);
      end
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign expire_o = expire_q;
endmodule

module timer_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick_in,
  timer_scheduler_if.slave     cfg,
  output logic [NUM_CH-1:0]    busy,
  output logic [NUM_CH-1:0]    expire,
  output logic                 irq,
  input  logic [NUM_CH-1:0]    irq_clr
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

  logic cfg_accept, cfg_bad, cmd_start, cmd_stop;
  logic cfg_err_q, cfg_err_d;

  assign cfg.cfg_ready = ~tick_in;
  assign cfg_accept    = cfg.cfg_valid & cfg.cfg_ready;
  assign cfg_bad       = (cfg.cfg_op == 2'b11)
                       | ((cfg.cfg_op != 2'b00) & (cfg.cfg_period == '0))
                       | ({1'b0, cfg.cfg_ch} >= NUM_CH_L);
  assign cmd_start     = cfg_accept & ~cfg_bad & (cfg.cfg_op != 2'b00);
  assign cmd_stop      = cfg_accept & ~cfg_bad & (cfg.cfg_op == 2'b00);

  always_comb cfg_err_d = cfg_accept & cfg_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_err_q <= 1'b0;
    else        cfg_err_q <= cfg_err_d;
  end
  assign cfg.cfg_err = cfg_err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic sel;
    assign sel = (cfg.cfg_ch == CH_W'(i));
    timer_scheduler_ch #(.CNT_W(CNT_W)) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick_i     (tick_in),
      .start_i    (cmd_start & sel),
      .periodic_i (cfg.cfg_op[1]),
      .stop_i     (cmd_stop & sel),
      .period_i   (cfg.cfg_period),
      .busy_o     (busy[i]),
      .expire_o   (expire[i])
    );
  end

`ifdef TIMER_SCHEDULER_IRQ_EN
  logic [NUM_CH-1:0] irq_sts_q, irq_sts_d;

  // Set wins over clear when both hit the same bit.
  always_comb irq_sts_d = (irq_sts_q & ~irq_clr) | expire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_sts_q <= '0;
    else        irq_sts_q <= irq_sts_d;
  end
  assign irq = |irq_sts_q;
`else
  logic unused_irq_clr;
  assign unused_irq_clr = ^irq_clr;
  assign irq            = 1'b0;
`endif
endmodule

// File: tb/tb_timer_scheduler.sv
// Randomized + directed bench for timer_scheduler against a tick-count reference model.
module tb_timer_scheduler;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              tick_in;
  logic [NUM_CH-1:0] busy, expire, irq_clr;
  logic              irq;

  timer_scheduler_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) cfg_if ();

  timer_scheduler #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick_in (tick_in),
    .cfg     (cfg_if),
    .busy    (busy),
    .expire  (expire),
    .irq     (irq),
    .irq_clr (irq_clr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference: a channel expires whenever the ticks counted since its start hit a multiple of its period.
  bit                m_run  [NUM_CH];
  bit                m_perd [NUM_CH];
  int                m_per  [NUM_CH];
  int                m_cnt  [NUM_CH];
  logic [NUM_CH-1:0] m_exp;
  logic [NUM_CH-1:0] m_sts;
  bit                m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_run[i] = 0; m_perd[i] = 0; m_per[i] = 0; m_cnt[i] = 0;
    end
    m_exp = '0; m_sts = '0; m_err = 0;
  endtask

  task automatic model_edge(input bit v, input int ch, input int op, input int per,
                            input bit tk, input logic [NUM_CH-1:0] clr);
`ifdef TIMER_SCHEDULER_IRQ_EN
    m_sts = (m_sts & ~clr) | m_exp;
`endif
    m_err = 0;
    m_exp = '0;
    if (v && !tk) begin
      if (op == 3 || (op != 0 && per == 0) || ch >= NUM_CH) m_err = 1;
      else if (op == 0) m_run[ch] = 0;
      else begin
        m_run[ch] = 1; m_perd[ch] = (op == 2); m_per[ch] = per; m_cnt[ch] = 0;
      end
    end
    if (tk) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (m_run[i]) begin
          m_cnt[i]++;
          if (m_cnt[i] % m_per[i] == 0) begin
            m_exp[i] = 1'b1;
            if (!m_perd[i]) m_run[i] = 0;
          end
        end
      end
    end
  endtask

  function automatic logic [NUM_CH-1:0] m_busy();
    logic [NUM_CH-1:0] b;
    for (int i = 0; i < NUM_CH; i++) b[i] = m_run[i];
    return b;
  endfunction

  task automatic check_outputs();
    chk("busy",    32'(busy),           32'(m_busy()));
    chk("expire",  32'(expire),         32'(m_exp));
    chk("cfg_err", 32'(cfg_if.cfg_err), 32'(m_err));
    chk("irq",     32'(irq),            32'(|m_sts));
  endtask

  task automatic cyc(input bit v, input int ch, input int op, input int per,
                     input bit tk, input logic [NUM_CH-1:0] clr);
    cfg_if.cfg_valid  = v;
    cfg_if.cfg_ch     = CH_W'(ch);
    cfg_if.cfg_op     = 2'(op);
    cfg_if.cfg_period = CNT_W'(per);
    tick_in           = tk;
    irq_clr           = clr;
    #1 chk("cfg_ready", 32'(cfg_if.cfg_ready), 32'(!tk));
    @(posedge clk);
    model_edge(v, ch, op, per, tk, clr);
    #1 check_outputs();
  endtask

  task automatic idle(input int n, input int tick_every);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, (k % tick_every) == tick_every - 1, '0);
  endtask

  task automatic async_reset();
    cfg_if.cfg_valid = 1'b0;
    tick_in          = 1'b0;
    irq_clr          = '0;
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_outputs();
    chk("rst_cfg_err", 32'(cfg_if.cfg_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_ch = '0; cfg_if.cfg_op = '0; cfg_if.cfg_period = '0;
    tick_in = 1'b0; irq_clr = '0;
    model_reset();
    #2 check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // One-shot ch0 P=3, tick every 10 clk.
    cyc(1, 0, 1, 3, 0, '0);
    idle(40, 10);
    // Periodic ch1 P=2 across 7 ticks, then stop.
    cyc(1, 1, 2, 2, 0, '0);
    idle(21, 3);
    cyc(1, 1, 0, 0, 0, '0);
    // Command held across a tick cycle is accepted the cycle after.
    cyc(1, 2, 1, 4, 1, '0);
    cyc(1, 2, 1, 4, 0, '0);
    // Rejected commands: zero period, reserved op; stop on idle is silent.
    cyc(1, 3, 1, 0, 0, '0);
    cyc(1, 3, 3, 5, 0, '0);
    cyc(1, 3, 0, 0, 0, '0);
    idle(2, 100);
    // Simultaneous expiry on ch0 and ch2, then clear irq status.
    cyc(1, 0, 1, 1, 0, '0);
    cyc(1, 2, 1, 1, 0, '0);
    cyc(0, 0, 0, 0, 1, '0);
    idle(4, 100);
    cyc(0, 0, 0, 0, 0, 4'b0101);
    idle(3, 100);
    // Reset mid-count on ch3 P=5 after 4 ticks; later ticks must stay quiet.
    cyc(1, 3, 1, 5, 0, '0);
    idle(8, 2);
    async_reset();
    idle(20, 2);

    // Random traffic; restarts on running channels and stop/clear collisions included.
    for (int k = 0; k < 3000; k++) begin
      int op, per;
      op  = $urandom_range(0, 3);
      per = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, NUM_CH - 1), op, per,
          $urandom_range(0, 3) == 0, NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1)) &
          NUM_CH'(($urandom_range(0, 3) == 0) ? '1 : '0));
      if (k == 1500) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/timer_scheduler.md
TIMER_SCHEDULER -- requirements
Module: timer_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, giving the number of independent timer channels (2..8).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the period and counter width in ticks.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port tick_in, input, 1 bit: one-clk-wide time-base pulse from the system clock divider.
REQ-006 The block SHALL have port cfg_valid, input, 1 bit: command request.
REQ-007 The block SHALL have port cfg_ready, output, 1 bit: command may be accepted this cycle.
REQ-008 The block SHALL have port cfg_ch, input, $clog2(NUM_CH) bits: target channel.
REQ-009 The block SHALL have port cfg_op, input, 2 bits: 00 stop, 01 start one-shot, 10 start periodic, 11 reserved.
REQ-010 The block SHALL have port cfg_period, input, CNT_W bits: period in ticks.
REQ-011 The block SHALL have port cfg_err, output, 1 bit: one-cycle pulse on a rejected command.
REQ-012 The block SHALL have port busy, output, NUM_CH bits: channel running.
REQ-013 The block SHALL have port expire, output, NUM_CH bits: one-cycle expiry pulse per channel.
REQ-014 The block SHALL have port irq, output, 1 bit: interrupt request.
REQ-015 The block SHALL have port irq_clr, input, NUM_CH bits: write-1-to-clear for interrupt status.

Function
REQ-016 Each channel SHALL be a state machine with states IDLE, ONESHOT and PERIODIC, plus a CNT_W-bit remaining counter.
REQ-017 cfg_ready SHALL equal the inverse of tick_in (combinational), so a tick cycle always stalls commands.
REQ-018 A command SHALL be accepted on a rising edge where cfg_valid and cfg_ready are both 1.
REQ-019 An accepted command SHALL be rejected, with cfg_err pulsed high for the next cycle and no state change, when cfg_op=11, when cfg_op is 01 or 10 with cfg_period=0, or when cfg_ch>=NUM_CH.
REQ-020 An accepted start command SHALL load remaining=cfg_period and enter ONESHOT (op 01) or PERIODIC (op 10).
REQ-021 A start command on a running channel SHALL restart that channel with the new period and mode, with no expire pulse.
REQ-022 A stop command SHALL force the channel to IDLE with remaining=0; stop on an IDLE channel SHALL have no effect and SHALL not raise cfg_err.
REQ-023 On each rising edge with tick_in=1, every running channel SHALL decrement remaining by 1.
REQ-024 When remaining=1 at a tick, the channel SHALL pulse expire[i] for exactly one cycle after that edge; ONESHOT SHALL then go to IDLE, and PERIODIC SHALL reload remaining=period and stay running.
REQ-025 The first tick counted after a start SHALL be the first tick_in sampled after the accepting edge, so period P yields expiry on exactly the P-th tick.
REQ-026 The PERIODIC reload value SHALL be held per channel and updated only by an accepted start command.
REQ-027 busy[i] SHALL be 1 in ONESHOT and PERIODIC, and 0 in IDLE.
REQ-028 All channels SHALL count and expire concurrently; simultaneous expiries SHALL each pulse their own expire bit in the same cycle.

Reset
REQ-029 When rst_n=0, all channels SHALL go to IDLE with remaining=0 and reload=0, and busy, expire, cfg_err, irq and irq status SHALL be 0, immediately and regardless of clk.
REQ-030 Reset asserted mid-count SHALL discard pending expiries; no expire pulse SHALL follow reset release until a new start completes.

Configuration
REQ-031 With macro TIMER_SCHEDULER_IRQ_EN defined, the block SHALL keep a NUM_CH-bit sticky status that sets on expire[i] and clears on irq_clr[i], and irq SHALL be the OR of the status bits.
REQ-032 With TIMER_SCHEDULER_IRQ_EN defined, a set from expire and a clear from irq_clr on the same bit in the same cycle SHALL leave the bit set.
REQ-033 Without TIMER_SCHEDULER_IRQ_EN, irq SHALL be constant 0, irq_clr SHALL be ignored, and no status register SHALL be built.

Verification
REQ-034 Start ch0 one-shot P=3, tick every 10 clk -> expire[0] one cycle after the 3rd tick, busy[0] drops then, no further pulses.
REQ-035 Start ch1 periodic P=2, 7 ticks -> expire[1] after ticks 2, 4 and 6; busy[1] stays 1.
REQ-036 cfg_valid held high across a tick_in cycle -> cfg_ready=0 that cycle, command accepted on the next cycle.
REQ-037 Start with P=0, then cfg_op=11 -> cfg_err pulses twice and busy is unchanged.
REQ-038 ch0 and ch2 both P=1, one tick -> expire=4'b0101 for one cycle; with the macro defined, irq=1 until irq_clr=4'b0101.
REQ-039 Assert rst_n=0 mid-count on ch3 P=5 after 4 ticks -> all outputs 0, and no expire on later ticks.
